pu_column_feeder: RTL

Upstream feeder for the img2col processing unit. Accepts pixel pairs from the AXI-side stream, writes each 5-pixel window column into the PU's 5-entry new-data register file two entries per cycle, then fires the PU's `start` with the current `round`. It waits for the PU to finish before loading the next column, and repeats for a programmed number of rounds per frame.

---
 rtl/pu_column_feeder_if.sv | 29 ++
 rtl/pu_column_feeder.sv | 82 ++++++++
 2 files changed

// File: rtl/pu_column_feeder_if.sv
// pu_column_feeder_if: frame control, pixel stream and PU write/start signals of the column feeder
interface pu_column_feeder_if #(
  parameter int data_width  = 16,
  parameter int address_num = 5
);
  logic                    frame_go;
  logic [5:0]              num_rounds;
  logic                    s_valid;
  logic [2*data_width-1:0] s_data;
  logic                    s_ready;
  logic                    pu_done;
  logic [data_width-1:0]   new1;
  logic [data_width-1:0]   new2;
  logic [address_num-1:0]  adrs_in1;
  logic [address_num-1:0]  adrs_in2;
  logic [address_num-1:0]  wr_ctrl_g;
  logic                    start;
  logic [5:0]              round;
  logic                    busy;
  logic                    frame_done;
  modport master (
    input  frame_go, num_rounds, s_valid, s_data, pu_done,
    output s_ready, new1, new2, adrs_in1, adrs_in2, wr_ctrl_g, start, round, busy, frame_done
  );
  modport slave (
    output frame_go, num_rounds, s_valid, s_data, pu_done,
    input  s_ready, new1, new2, adrs_in1, adrs_in2, wr_ctrl_g, start, round, busy, frame_done
  );
endinterface

// File: rtl/pu_column_feeder.sv
// pu_column_feeder: loads 5-pixel columns into the PU new-reg file two entries per beat, then fires start per round
module pu_column_feeder #(
  parameter int data_width  = 16,
  parameter int address_num = 5
) (
  input logic clk,
  input logic nrst,
  pu_column_feeder_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;
  state_t state, state_nx;
  logic [1:0]             k;
  logic [5:0]             nr_q;
  logic [5:0]             round_q;
  logic                   start_q;
  logic                   fd_q;
  logic [address_num-1:0] a1_q, a2_q, wr_q;
  logic [data_width-1:0]  n1_q, n2_q;
  logic                   acc, go, done_ok, last;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state;
    go       = state == IDLE && bus.frame_go && bus.num_rounds != 6'd0;
    acc      = state == LOAD && bus.s_valid;
    // a pu_done coincident with start belongs to the previous column and is dropped
    done_ok  = state == WAIT && bus.pu_done && !start_q;
    last     = round_q == nr_q - 6'd1;
    unique case (state)
      IDLE: state_nx = go ? LOAD : IDLE;
      LOAD: state_nx = (acc && k == 2'd2) ? FIRE : LOAD;
      FIRE: state_nx = WAIT;
      WAIT: state_nx = done_ok ? (last ? IDLE : LOAD) : WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      k       <= '0;
      nr_q    <= '0;
      round_q <= '0;
      start_q <= 1'b0;
      fd_q    <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      wr_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
    end else begin
      wr_q    <= '0;
      start_q <= state == FIRE;
      fd_q    <= (state == IDLE && bus.frame_go && bus.num_rounds == 6'd0) || (done_ok && last);
      if (go) begin
        nr_q    <= bus.num_rounds;
        round_q <= '0;
        k       <= '0;
      end
      if (done_ok && !last) begin
        round_q <= round_q + 6'd1;
        k       <= '0;
      end
      // beat k fills entries 2k and 2k+1; the last beat only has entry 4
      if (acc) begin
        k    <= k == 2'd2 ? 2'd0 : k + 2'd1;
        a1_q <= address_num'({k, 1'b0});
        a2_q <= k == 2'd2 ? address_num'(4) : address_num'({k, 1'b1});
        wr_q <= k == 2'd0 ? address_num'(5'b00011) : k == 2'd1 ? address_num'(5'b01100) : address_num'(5'b10000);
        n1_q <= bus.s_data[data_width-1:0];
        n2_q <= k == 2'd2 ? '0 : bus.s_data[2*data_width-1:data_width];
      end
    end
  assign bus.s_ready    = state == LOAD;
  assign bus.busy       = state != IDLE;
  assign bus.start      = start_q;
  assign bus.round      = round_q;
  assign bus.frame_done = fd_q;
  assign bus.adrs_in1   = a1_q;
  assign bus.adrs_in2   = a2_q;
  assign bus.wr_ctrl_g  = wr_q;
  assign bus.new1       = n1_q;
  assign bus.new2       = n2_q;
endmodule
